spi_slave_regs: RTL and testbench
=================================

# spi_slave_regs

SPI mode-0 slave that terminates the 24-bit command/address/payload frame driven by `spi_master_mock`. It oversamples `cs`/`sclk`/`mosi` in the `sysclk` domain, decodes write and read commands against a small internal register file, and returns read data on `miso` during the payload phase of the same frame. Register 0 drives the brightness output consumed by the LED logic.

## Interface
Parameters:
- `REG_DEPTH`, default 16: number of 8-bit registers. Addresses `>= REG_DEPTH` are out of range.
- `SYNC_STAGES`, default 2: synchronizer flops on `cs`, `sclk` and `mosi`.

Ports:
- `sysclk`  in  1: system clock, 125 MHz. Single clock domain.
- `rst`  in  1: asynchronous, active-high reset.
- `cs`  in  1: chip select. Active level is `CS_ASSERT`; idle level is `CS_DEASSERT`.
- `sclk`  in  1: SPI clock, idle low (CPOL=0).
- `mosi`  in  1: serial data from the master, MSB first.
- `miso`  out  1: serial data to the master, MSB first.
- `o_wr_strobe`  out  1: one-cycle pulse when a write commits.
- `o_wr_addr`  out  `ADDR_BITS`: address of the last committed write.
- `o_wr_data`  out  `PAYLOAD_BITS`: data of the last committed write.
- `o_frame`  out  `BRIGHTNESS_WIDTH`: equals `reg[0][7:1]`.
- `o_frame_err`  out  1: one-cycle pulse when a frame is aborted or carries an unknown command.

Reset values: `miso`, `o_wr_strobe`, `o_wr_addr`, `o_wr_data`, `o_frame`, `o_frame_err` are all 0. All registers reset to 0x00.

## Operation
- Inputs pass through `SYNC_STAGES` flops. Edge detection compares the last two synchronized `sclk` samples.
- Mode 0 timing: `mosi` is sampled on the `sclk` rising edge; `miso` is updated on the `sclk` falling edge.
- Frame layout: `CMD_BITS`=8, then `ADDR_BITS`=8, then `PAYLOAD_BITS`=8, for `MASTER_FRAME_WIDTH`=24 bits.
- Commands: `CMD_WRITE`=0x80, `CMD_READ`=0x40. Any other value is unknown.
- FSM states: IDLE, CMD, ADDR, PAYLOAD, DONE.
  - IDLE -> CMD on synchronized `cs` going to `CS_ASSERT`. The bit counter clears.
  - CMD -> ADDR after the 8th rising edge. The command is latched.
  - ADDR -> PAYLOAD after the 16th rising edge. The address is latched. For a read, the read shift register loads `reg[addr]`, or 0x00 if the address is out of range.
  - PAYLOAD -> DONE after the 24th rising edge. A write commits: `reg[addr]` is updated, `o_wr_*` are updated, and `o_wr_strobe` pulses. An out-of-range write updates nothing and pulses `o_frame_err`.
  - DONE ignores any further `sclk` edges. It returns to IDLE when `cs` deasserts.
- `miso` behaviour:
  - In IDLE, CMD and ADDR, `miso` is 0.
  - For a read, bit 7 of the read data is driven on the falling edge after the 16th rising edge. The next bit is driven on each subsequent falling edge.
  - For writes and unknown commands, `miso` is 0 throughout the payload phase.
- Unknown command: no write, `miso` stays 0, and `o_frame_err` pulses at the end of CMD.
- Abort: if `cs` deasserts before the 24th rising edge, the frame is discarded, nothing is written, `o_frame_err` pulses, and the FSM goes to IDLE.

## Timing
- `sclk` period must be at least 8 `sysclk` periods, and each `sclk` phase at least 4. The bench runs `sysclk` at 8 ns and `sclk` at 80 ns.
- Edge-detect latency is `SYNC_STAGES`+1 `sysclk` cycles after the pin edge.
  - A `miso` update lands at most `SYNC_STAGES`+2 cycles after the falling `sclk` edge.
  - This is well before the next rising edge.
- A write commit becomes visible on `o_wr_*`, `o_frame` and `o_wr_strobe` `SYNC_STAGES`+2 `sysclk` cycles after the 24th rising `sclk` edge.
- A `cs` assertion and the first `sclk` rising edge seen in the same `sysclk` cycle are handled as IDLE -> CMD followed by sampling that edge: no bit is lost.
- If `cs` deassertion and the 24th rising edge are seen in the same cycle, the deassertion wins and the frame aborts.
- `rst` mid-frame: asynchronous return to IDLE, registers cleared, no strobe.

## Structure
- `params.vh` holds the shared constants:
  - `CMD_BITS`, `ADDR_BITS`, `PAYLOAD_BITS`, `MASTER_FRAME_WIDTH`, `BRIGHTNESS_WIDTH`.
  - `CS_ASSERT`, `CS_DEASSERT`.
  - Add `CMD_WRITE`, `CMD_READ` and the FSM state encodings there.
- Sub-module `spi_regfile`:
  - `REG_DEPTH` x 8 storage, asynchronous reset.
  - One synchronous write port and one combinational read port, with out-of-range reads returning 0.
  - Exposes `reg0` for `o_frame`.
- The top level holds the synchronizers, edge detect, FSM, bit counter and shift registers.

## Test plan
- Reset held, then released with `cs` idle -> `miso`=0, all outputs 0, `o_frame`=0.
- Write frame {0x80, 0x00, 0xD0} -> one `o_wr_strobe`, `o_wr_addr`=0x00, `o_wr_data`=0xD0, `o_frame`=7'b1101000.
- Write {0x80, 0x05, 0x98}, then read frame {0x40, 0x05, xx} -> `miso` in the payload phase carries 1,0,0,1,1,0,0,0 and stays 0 during cmd/addr; no write strobe.
- Read of out-of-range address {0x40, 0x20, xx} -> `miso` all 0; write {0x80, 0x20, 0x55} -> no strobe, `o_frame_err` pulse, registers unchanged.
- Abort: deassert `cs` after 12 bits of a write frame -> no strobe, one `o_frame_err` pulse; the next full frame writes correctly.
- Unknown command 0x11 -> `o_frame_err` pulse after 8 bits, no write. Extra `sclk` pulses after bit 24 of a valid write -> ignored, exactly one strobe.

Source files
------------

// File: rtl/spi_slave_regs_pkg.sv
// Shared constants, command codes and FSM encoding for the SPI register slave.
`timescale 1ns/1ps
package spi_slave_regs_pkg;

  localparam int CMD_BITS           = 8;
  localparam int ADDR_BITS          = 8;
  localparam int PAYLOAD_BITS       = 8;
  localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
  localparam int BRIGHTNESS_WIDTH   = 7;
  localparam int CNT_BITS           = 5;

  // Chip select is active low on the board.
  localparam logic CS_ASSERT   = 1'b0;
  localparam logic CS_DEASSERT = 1'b1;

  localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h80;
  localparam logic [CMD_BITS-1:0] CMD_READ  = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic is_known_cmd(input logic [CMD_BITS-1:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_regfile.sv
// REG_DEPTH x 8 register file: one synchronous write port, one combinational read port.
`timescale 1ns/1ps
module spi_regfile
  import spi_slave_regs_pkg::*;
#(
  parameter int REG_DEPTH = 16
) (
  input  logic                        sysclk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ADDR_BITS-1:0]        waddr,
  input  logic [PAYLOAD_BITS-1:0]     wdata,
  input  logic [ADDR_BITS-1:0]        raddr,
  output logic [PAYLOAD_BITS-1:0]     rdata,
  output logic [BRIGHTNESS_WIDTH-1:0] reg0_bright
);

  localparam int          IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [31:0] DEPTH = 32'(REG_DEPTH);

  logic [PAYLOAD_BITS-1:0] regs [REG_DEPTH];
  logic                    w_ok;
  logic                    r_ok;

  // Out-of-range accesses never touch storage; reads of them return zero.
  always_comb begin
    w_ok = 32'(waddr) < DEPTH;
    r_ok = 32'(raddr) < DEPTH;
    rdata = '0;
    if (r_ok) begin
      rdata = regs[raddr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && w_ok) begin
      regs[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign reg0_bright = regs[0][PAYLOAD_BITS-1:PAYLOAD_BITS-BRIGHTNESS_WIDTH];

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave: oversampled cs/sclk/mosi, 24-bit cmd/addr/payload frames
// against a small register file; read data returned on miso in the same frame.
`timescale 1ns/1ps
module spi_slave_regs
  import spi_slave_regs_pkg::*;
#(
  parameter int REG_DEPTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        sysclk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        sclk,
  input  logic                        mosi,
  output logic                        miso,
  output logic                        o_wr_strobe,
  output logic [ADDR_BITS-1:0]        o_wr_addr,
  output logic [PAYLOAD_BITS-1:0]     o_wr_data,
  output logic [BRIGHTNESS_WIDTH-1:0] o_frame,
  output logic                        o_frame_err
);

  localparam logic [31:0]         DEPTH    = 32'(REG_DEPTH);
  localparam logic [CNT_BITS-1:0] CMD_END  = CNT_BITS'(CMD_BITS);
  localparam logic [CNT_BITS-1:0] ADDR_END = CNT_BITS'(CMD_BITS + ADDR_BITS);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(MASTER_FRAME_WIDTH);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic cs_active;
  logic sclk_rise;
  logic sclk_fall;

  state_t                  state;
  logic [CNT_BITS-1:0]     bit_cnt;
  logic [PAYLOAD_BITS-2:0] shift_in;
  logic [CMD_BITS-1:0]     cmd;
  logic [ADDR_BITS-1:0]    addr;
  logic [PAYLOAD_BITS-1:0] rd_shift;

  logic [PAYLOAD_BITS-1:0] shift_next;
  logic [CNT_BITS-1:0]     cnt_next;
  logic                    addr_in_range;
  logic                    last_bit;
  logic                    commit;
  logic [PAYLOAD_BITS-1:0] rdata;

  // Every pin goes through its own synchronizer chain; sclk_prev gives the edge history.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cs_sync   <= {SYNC_STAGES{CS_DEASSERT}};
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_active = (cs_s == CS_ASSERT);
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  // The commit is decoded combinationally so the regfile and o_wr_* update on the same edge.
  always_comb begin
    shift_next    = {shift_in, mosi_s};
    cnt_next      = bit_cnt + 1'b1;
    addr_in_range = 32'(addr) < DEPTH;
    last_bit      = (state == ST_PAYLOAD) && cs_active && sclk_rise && (cnt_next == LAST_CNT);
    commit        = last_bit && (cmd == CMD_WRITE) && addr_in_range;
  end

  spi_regfile #(
    .REG_DEPTH (REG_DEPTH)
  ) u_regfile (
    .sysclk      (sysclk),
    .rst         (rst),
    .we          (commit),
    .waddr       (addr),
    .wdata       (shift_next),
    .raddr       (shift_next),
    .rdata       (rdata),
    .reg0_bright (o_frame)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_in    <= '0;
      cmd         <= '0;
      addr        <= '0;
      rd_shift    <= '0;
      miso        <= 1'b0;
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_wr_strobe <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (cs_active) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
            // A rising edge seen together with cs assertion is still the first bit.
            if (sclk_rise) begin
              shift_in <= shift_next[PAYLOAD_BITS-2:0];
              bit_cnt  <= {{(CNT_BITS-1){1'b0}}, 1'b1};
            end
          end
        end

        ST_CMD: begin
          if (!cs_active) begin
            state       <= ST_IDLE;
            o_frame_err <= 1'b1;
          end else if (sclk_rise) begin
            shift_in <= shift_next[PAYLOAD_BITS-2:0];
            bit_cnt  <= cnt_next;
            if (cnt_next == CMD_END) begin
              cmd   <= shift_next;
              state <= ST_ADDR;
              if (!is_known_cmd(shift_next)) begin
                o_frame_err <= 1'b1;
              end
            end
          end
        end

        ST_ADDR: begin
          if (!cs_active) begin
            state       <= ST_IDLE;
            o_frame_err <= 1'b1;
          end else if (sclk_rise) begin
            shift_in <= shift_next[PAYLOAD_BITS-2:0];
            bit_cnt  <= cnt_next;
            if (cnt_next == ADDR_END) begin
              addr     <= shift_next;
              state    <= ST_PAYLOAD;
              rd_shift <= (cmd == CMD_READ) ? rdata : '0;
            end
          end
        end

        ST_PAYLOAD: begin
          if (!cs_active) begin
            state       <= ST_IDLE;
            miso        <= 1'b0;
            o_frame_err <= 1'b1;
          end else if (sclk_rise) begin
            shift_in <= shift_next[PAYLOAD_BITS-2:0];
            bit_cnt  <= cnt_next;
            if (last_bit) begin
              state <= ST_DONE;
              if (commit) begin
                o_wr_strobe <= 1'b1;
                o_wr_addr   <= addr;
                o_wr_data   <= shift_next;
              end else if (cmd == CMD_WRITE) begin
                o_frame_err <= 1'b1;
              end
            end
          end else if (sclk_fall) begin
            miso     <= rd_shift[PAYLOAD_BITS-1];
            rd_shift <= {rd_shift[PAYLOAD_BITS-2:0], 1'b0};
          end
        end

        ST_DONE: begin
          if (!cs_active) begin
            state <= ST_IDLE;
            miso  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Scoreboard bench for spi_slave_regs: bit-banged mode-0 frames, miso and write events checked against a register model.
`timescale 1ns/1ps
module tb_spi_slave_regs;
  import spi_slave_regs_pkg::*;

  logic sysclk = 1'b0;
  logic rst;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;
  logic o_wr_strobe;
  logic [ADDR_BITS-1:0] o_wr_addr;
  logic [PAYLOAD_BITS-1:0] o_wr_data;
  logic [BRIGHTNESS_WIDTH-1:0] o_frame;
  logic o_frame_err;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_wr_q[$];
  logic exp_miso_q[$];
  logic [7:0] model_regs [16];

  always #4 sysclk = ~sysclk;

  spi_slave_regs #(
    .REG_DEPTH   (16),
    .SYNC_STAGES (2)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .cs          (cs),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .o_wr_strobe (o_wr_strobe),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_frame     (o_frame),
    .o_frame_err (o_frame_err)
  );

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Write events are popped from the scoreboard as the DUT strobes them.
  always @(negedge sysclk) begin
    if (!rst) begin
      if (o_wr_strobe) begin
        strobe_cnt++;
        check_output("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check_output("wr_addr", 32'(o_wr_addr), 32'(e.addr));
          check_output("wr_data", 32'(o_wr_data), 32'(e.data));
        end
      end
      if (o_frame_err) begin
        err_cnt++;
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                                input int nbits, input int extra);
    logic [23:0] frame;
    logic [7:0] rd;
    logic unknown;
    logic oor;
    int s0;
    int e0;
    int exp_s;
    int exp_e;
    frame   = {c, a, d};
    unknown = (c != 8'h80) && (c != 8'h40);
    oor     = (a >= 8'd16);
    rd      = (c == 8'h40 && !oor) ? model_regs[a[3:0]] : 8'h00;
    exp_s   = (nbits == 24 && c == 8'h80 && !oor) ? 1 : 0;
    exp_e   = ((nbits < 24) ? 1 : 0) + ((nbits >= 8 && unknown) ? 1 : 0)
            + ((nbits == 24 && c == 8'h80 && oor) ? 1 : 0);
    for (int i = 0; i < nbits; i++) begin
      exp_miso_q.push_back((i >= 16) ? rd[23 - i] : 1'b0);
    end
    if (exp_s == 1) begin
      exp_wr_q.push_back('{addr: a, data: d});
      model_regs[a[3:0]] = d;
    end
    s0 = strobe_cnt;
    e0 = err_cnt;
    cs = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[23 - i];
      #38;
      check_output($sformatf("miso_bit%0d", i), 32'(miso), 32'(exp_miso_q.pop_front()));
      #2;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
    for (int k = 0; k < extra; k++) begin
      mosi = 1'($urandom_range(0, 1));
      #40;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
    #40;
    cs = 1'b1;
    #166;
    check_output("strobe_count", 32'(strobe_cnt - s0), 32'(exp_s));
    check_output("frame_err_count", 32'(err_cnt - e0), 32'(exp_e));
    check_output("o_frame", 32'(o_frame), 32'(model_regs[0][7:1]));
    check_output("miso_idle", 32'(miso), 32'd0);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    #78;
    check_output("rst_miso", 32'(miso), 32'd0);
    check_output("rst_wr_strobe", 32'(o_wr_strobe), 32'd0);
    check_output("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check_output("rst_wr_data", 32'(o_wr_data), 32'd0);
    check_output("rst_frame", 32'(o_frame), 32'd0);
    check_output("rst_frame_err", 32'(o_frame_err), 32'd0);
    #2;
    rst = 1'b0;
    #78;
    check_output("idle_miso", 32'(miso), 32'd0);
    check_output("idle_wr_strobe", 32'(o_wr_strobe), 32'd0);
    check_output("idle_frame", 32'(o_frame), 32'd0);
    check_output("idle_frame_err", 32'(o_frame_err), 32'd0);
    #2;

    apply_stimulus(8'h80, 8'h00, 8'hD0, 24, 0);
    check_output("frame_d0", 32'(o_frame), 32'h68);

    apply_stimulus(8'h80, 8'h05, 8'h98, 24, 0);
    apply_stimulus(8'h40, 8'h05, 8'($urandom), 24, 0);

    apply_stimulus(8'h40, 8'h20, 8'($urandom), 24, 0);
    apply_stimulus(8'h80, 8'h20, 8'h55, 24, 0);
    apply_stimulus(8'h40, 8'h05, 8'($urandom), 24, 0);
    apply_stimulus(8'h40, 8'h00, 8'($urandom), 24, 0);

    apply_stimulus(8'h80, 8'h03, 8'hAA, 12, 0);
    apply_stimulus(8'h40, 8'h03, 8'($urandom), 24, 0);
    apply_stimulus(8'h80, 8'h03, 8'h3C, 24, 0);
    apply_stimulus(8'h40, 8'h03, 8'($urandom), 24, 0);

    apply_stimulus(8'h11, 8'h04, 8'h77, 24, 0);
    apply_stimulus(8'h40, 8'h04, 8'($urandom), 24, 0);

    apply_stimulus(8'h80, 8'h07, 8'hC3, 24, 5);
    apply_stimulus(8'h40, 8'h07, 8'($urandom), 24, 0);

    apply_stimulus(8'h80, 8'h00, 8'h2B, 24, 0);
    apply_stimulus(8'h40, 8'h00, 8'($urandom), 24, 0);

    check_output("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
